// File: rtl/ram18k_fifo_pkg.sv
// rtl/ram18k_fifo_pkg.sv - shared sizes and pointer-to-RAM-address mapping for the RAM18K FIFO
package ram18k_fifo_pkg;

  localparam int FIFO_DEPTH   = 1024;
  localparam int PTR_W        = 11;
  localparam int DATA_W       = 18;
  localparam int RAM_ADDR_W   = 14;
  localparam int ADDR_LSB_PAD = 4;

  // The x18 aspect ratio of the RAM18K half addresses words on bit 4 and up.
  function automatic logic [RAM_ADDR_W-1:0] ptr_to_ram_addr(input logic [PTR_W-2:0] ram_idx);
    return {ram_idx, {ADDR_LSB_PAD{1'b0}}};
  endfunction

endpackage

// File: rtl/ram18k_fifo_ptr.sv
// rtl/ram18k_fifo_ptr.sv - 11-bit wrapping FIFO pointer with increment, clear and RAM address
module ram18k_fifo_ptr
  import ram18k_fifo_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  inc,
  output logic [RAM_ADDR_W-1:0] addr
);

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [PTR_W-1:0] ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (clr) begin
      ptr_q <= '0;
    end else if (inc) begin
      ptr_q <= ptr_q + PTR_ONE;
    end
  end

  assign addr = ptr_to_ram_addr(ptr_q[PTR_W-2:0]);

endmodule

// File: rtl/ram18k_fifo_ctrl.sv
// rtl/ram18k_fifo_ctrl.sv - 1024x18 FIFO controller sequencing one half of a TDP_RAM18KX2
module ram18k_fifo_ctrl
  import ram18k_fifo_pkg::*;
#(
  parameter int ALMOST_FULL_OFFSET  = 16,
  parameter int ALMOST_EMPTY_OFFSET = 16
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  FLUSH,
  input  logic                  PUSH,
  input  logic [DATA_W-1:0]     WDATA,
  input  logic                  POP,
  output logic [DATA_W-1:0]     RDATA,
  output logic                  RVALID,
  output logic                  FULL,
  output logic                  ALMOST_FULL,
  output logic                  EMPTY,
  output logic                  ALMOST_EMPTY,
  output logic [PTR_W-1:0]      COUNT,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW,
  output logic                  RAM_WEN_A,
  output logic [1:0]            RAM_BE_A,
  output logic [RAM_ADDR_W-1:0] RAM_ADDR_A,
  output logic [DATA_W-1:0]     RAM_WDATA_A,
  output logic                  RAM_REN_B,
  output logic [RAM_ADDR_W-1:0] RAM_ADDR_B,
  input  logic [DATA_W-1:0]     RAM_RDATA_B
);

  localparam logic [PTR_W-1:0] CNT_ONE   = PTR_W'(1);
  localparam logic [PTR_W-1:0] DEPTH_CNT = PTR_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] AF_LEVEL  = PTR_W'(FIFO_DEPTH - ALMOST_FULL_OFFSET);
  localparam logic [PTR_W-1:0] AE_LEVEL  = PTR_W'(ALMOST_EMPTY_OFFSET);

  logic                  push_acc;
  logic                  pop_acc;
  logic [PTR_W-1:0]      count_q;
  logic [PTR_W-1:0]      count_nxt;
  logic                  full_q;
  logic                  afull_q;
  logic                  empty_q;
  logic                  aempty_q;
  logic                  ovf_q;
  logic                  unf_q;
  logic                  rvalid_q;
  logic [RAM_ADDR_W-1:0] waddr;
  logic [RAM_ADDR_W-1:0] raddr;

  // Flush masks both requests so the RAM is left untouched in the flush cycle.
  assign push_acc = PUSH & ~full_q & ~FLUSH;
  assign pop_acc  = POP & ~empty_q & ~FLUSH;

  always_comb begin
    count_nxt = count_q;
    if (FLUSH) begin
      count_nxt = '0;
    end else if (push_acc && !pop_acc) begin
      count_nxt = count_q + CNT_ONE;
    end else if (pop_acc && !push_acc) begin
      count_nxt = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      count_q  <= '0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      empty_q  <= 1'b1;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      count_q  <= count_nxt;
      full_q   <= (count_nxt == DEPTH_CNT);
      afull_q  <= (count_nxt >= AF_LEVEL);
      empty_q  <= (count_nxt == '0);
      aempty_q <= (count_nxt <= AE_LEVEL);
      ovf_q    <= PUSH & full_q & ~FLUSH;
      unf_q    <= POP & empty_q & ~FLUSH;
      rvalid_q <= pop_acc;
    end
  end

  ram18k_fifo_ptr u_wptr (
    .clk   (CLK),
    .rst_n (RESET_N),
    .clr   (FLUSH),
    .inc   (push_acc),
    .addr  (waddr)
  );

  ram18k_fifo_ptr u_rptr (
    .clk   (CLK),
    .rst_n (RESET_N),
    .clr   (FLUSH),
    .inc   (pop_acc),
    .addr  (raddr)
  );

  assign RAM_WEN_A   = push_acc;
  assign RAM_BE_A    = {2{push_acc}};
  assign RAM_ADDR_A  = waddr;
  assign RAM_WDATA_A = WDATA;
  assign RAM_REN_B   = pop_acc;
  assign RAM_ADDR_B  = raddr;

  assign RVALID       = rvalid_q;
  assign RDATA        = rvalid_q ? RAM_RDATA_B : '0;
  assign COUNT        = count_q;
  assign FULL         = full_q;
  assign ALMOST_FULL  = afull_q;
  assign EMPTY        = empty_q;
  assign ALMOST_EMPTY = aempty_q;
  assign OVERFLOW     = ovf_q;
  assign UNDERFLOW    = unf_q;

endmodule

// File: tb/tb_ram18k_fifo_ctrl.sv
// tb/tb_ram18k_fifo_ctrl.sv - randomized self-checking bench for ram18k_fifo_ctrl
module tb_ram18k_fifo_ctrl;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        FLUSH = 1'b0;
  logic        PUSH = 1'b0;
  logic [17:0] WDATA = '0;
  logic        POP = 1'b0;
  logic [17:0] RDATA;
  logic        RVALID;
  logic        FULL, ALMOST_FULL, EMPTY, ALMOST_EMPTY;
  logic [10:0] COUNT;
  logic        OVERFLOW, UNDERFLOW;
  logic        RAM_WEN_A;
  logic [1:0]  RAM_BE_A;
  logic [13:0] RAM_ADDR_A;
  logic [17:0] RAM_WDATA_A;
  logic        RAM_REN_B;
  logic [13:0] RAM_ADDR_B;
  logic [17:0] RAM_RDATA_B;

  ram18k_fifo_ctrl #(
    .ALMOST_FULL_OFFSET  (16),
    .ALMOST_EMPTY_OFFSET (16)
  ) dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .FLUSH        (FLUSH),
    .PUSH         (PUSH),
    .WDATA        (WDATA),
    .POP          (POP),
    .RDATA        (RDATA),
    .RVALID       (RVALID),
    .FULL         (FULL),
    .ALMOST_FULL  (ALMOST_FULL),
    .EMPTY        (EMPTY),
    .ALMOST_EMPTY (ALMOST_EMPTY),
    .COUNT        (COUNT),
    .OVERFLOW     (OVERFLOW),
    .UNDERFLOW    (UNDERFLOW),
    .RAM_WEN_A    (RAM_WEN_A),
    .RAM_BE_A     (RAM_BE_A),
    .RAM_ADDR_A   (RAM_ADDR_A),
    .RAM_WDATA_A  (RAM_WDATA_A),
    .RAM_REN_B    (RAM_REN_B),
    .RAM_ADDR_B   (RAM_ADDR_B),
    .RAM_RDATA_B  (RAM_RDATA_B)
  );

  always #5 CLK = ~CLK;

  // Behavioural RAM18K half: registered read, one cycle latency.
  logic [17:0] mem [0:1023];
  always @(posedge CLK) begin
    if (RAM_WEN_A && RAM_BE_A == 2'b11) mem[RAM_ADDR_A[13:4]] <= RAM_WDATA_A;
    if (RAM_REN_B) RAM_RDATA_B <= mem[RAM_ADDR_B[13:4]];
  end

  int n_checks = 0;
  int n_errors = 0;

  logic [17:0] model_q[$];
  int          wcnt = 0;
  int          rcnt = 0;
  logic        exp_ovf = 1'b0;
  logic        exp_unf = 1'b0;
  logic        exp_rv = 1'b0;
  logic [17:0] exp_rd = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    wcnt = 0;
    rcnt = 0;
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    exp_rv = 1'b0;
  endtask

  // One clock cycle: drive, check at the falling edge, advance the model.
  task automatic step(input logic push, input logic pop, input logic flush, input logic [17:0] wd);
    int   sz;
    logic pa, pp;
    PUSH = push; POP = pop; FLUSH = flush; WDATA = wd;
    @(negedge CLK);
    sz = model_q.size();
    pa = push && !flush && sz < 1024;
    pp = pop && !flush && sz > 0;
    check("count", 32'(COUNT), 32'(sz));
    check("full", 32'(FULL), 32'(sz == 1024));
    check("almost_full", 32'(ALMOST_FULL), 32'(sz >= 1008));
    check("empty", 32'(EMPTY), 32'(sz == 0));
    check("almost_empty", 32'(ALMOST_EMPTY), 32'(sz <= 16));
    check("overflow", 32'(OVERFLOW), 32'(exp_ovf));
    check("underflow", 32'(UNDERFLOW), 32'(exp_unf));
    check("rvalid", 32'(RVALID), 32'(exp_rv));
    check("rdata", 32'(RDATA), exp_rv ? 32'(exp_rd) : 32'd0);
    check("ram_wen_a", 32'(RAM_WEN_A), 32'(pa));
    check("ram_be_a", 32'(RAM_BE_A), pa ? 32'd3 : 32'd0);
    check("ram_ren_b", 32'(RAM_REN_B), 32'(pp));
    if (pa) begin
      check("ram_addr_a", 32'(RAM_ADDR_A), 32'((wcnt % 1024) * 16));
      check("ram_wdata_a", 32'(RAM_WDATA_A), 32'(wd));
    end
    if (pp) check("ram_addr_b", 32'(RAM_ADDR_B), 32'((rcnt % 1024) * 16));
    if (flush) begin
      model_reset();
    end else begin
      exp_ovf = push && sz == 1024;
      exp_unf = pop && sz == 0;
      exp_rv = pp;
      if (pp) begin
        exp_rd = model_q.pop_front();
        rcnt++;
      end
      if (pa) begin
        model_q.push_back(wd);
        wcnt++;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #1 RESET_N = 1'b1;

    repeat (3) step(1'b0, 1'b0, 1'b0, 18'h0);

    // Fill to full, then one push too many.
    for (int i = 1; i <= 1024; i++) step(1'b1, 1'b0, 1'b0, 18'(i));
    step(1'b1, 1'b0, 1'b0, 18'h3ffff);
    step(1'b0, 1'b0, 1'b0, 18'h0);

    // Drain fully, then one pop too many.
    for (int i = 0; i < 1024; i++) step(1'b0, 1'b1, 1'b0, 18'h0);
    step(1'b0, 1'b1, 1'b0, 18'h0);
    step(1'b0, 1'b0, 1'b0, 18'h0);

    // Pre-fill 5 then sustained push+pop across several pointer wraps.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 18'($urandom));
    for (int i = 0; i < 3000; i++) step(1'b1, 1'b1, 1'b0, 18'($urandom));
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 18'h0);

    // Push+pop while empty, then while full.
    step(1'b1, 1'b1, 1'b0, 18'h12345);
    step(1'b0, 1'b0, 1'b0, 18'h0);
    for (int i = 0; i < 1023; i++) step(1'b1, 1'b0, 1'b0, 18'($urandom));
    step(1'b1, 1'b1, 1'b0, 18'h2aaaa);
    step(1'b0, 1'b0, 1'b0, 18'h0);

    // Flush with 10 stored and a read in flight.
    step(1'b0, 1'b0, 1'b1, 18'h0);
    for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 1'b0, 18'($urandom));
    step(1'b0, 1'b1, 1'b0, 18'h0);
    step(1'b1, 1'b1, 1'b1, 18'h15555);
    step(1'b0, 1'b0, 1'b0, 18'h0);

    // Random mix including rare flushes.
    for (int i = 0; i < 1500; i++)
      step(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45),
           1'($urandom_range(0, 199) == 0), 18'($urandom));

    // Reset during an outstanding pop.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 18'($urandom));
    step(1'b0, 1'b1, 1'b0, 18'h0);
    PUSH = 1'b0; POP = 1'b0; FLUSH = 1'b0;
    #2 RESET_N = 1'b0;
    #1;
    check("rst_rvalid", 32'(RVALID), 32'd0);
    check("rst_rdata", 32'(RDATA), 32'd0);
    check("rst_count", 32'(COUNT), 32'd0);
    check("rst_empty", 32'(EMPTY), 32'd1);
    model_reset();
    @(posedge CLK);
    #1 RESET_N = 1'b1;
    repeat (3) step(1'b0, 1'b0, 1'b0, 18'h0);
    step(1'b1, 1'b0, 1'b0, 18'h0abcd);
    step(1'b0, 1'b1, 1'b0, 18'h0);
    step(1'b0, 1'b0, 1'b0, 18'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ram18k_fifo_ctrl.md
# ram18k_fifo_ctrl

Single-clock FIFO controller that sequences one half of a TDP_RAM18KX2 as a 1024 x 18 FIFO. Port A of the half is write-only, port B is read-only. The block owns the write and read pointers, the occupancy count, the status flags and the error pulses. It sits between a streaming producer/consumer pair and the RAM primitive; the RAM itself is instantiated outside this block.

## Interface
- Clocking: one clock `CLK`; reset `RESET_N` is asynchronous and active-low.
- `ALMOST_FULL_OFFSET`, 16: `ALMOST_FULL` asserts when count >= 1024 - offset. Legal range 1..1023.
- `ALMOST_EMPTY_OFFSET`, 16: `ALMOST_EMPTY` asserts when count <= offset. Legal range 1..1023.
- `CLK` in 1: sole clock; all state on the rising edge.
- `RESET_N` in 1: asynchronous assert, synchronous deassert expected from the upstream reset synchronizer.
- `FLUSH` in 1: synchronous clear of pointers and count.
- `PUSH` in 1: write request.
- `WDATA` in 18: write data.
- `POP` in 1: read request.
- `RDATA` out 18: read data, valid when `RVALID`.
- `RVALID` out 1: read data valid.
- `FULL`, `ALMOST_FULL`, `EMPTY`, `ALMOST_EMPTY` out 1 each: registered status.
- `COUNT` out 11: occupancy, 0..1024.
- `OVERFLOW`, `UNDERFLOW` out 1 each: one-cycle error pulses.
- `RAM_WEN_A` out 1: write enable to the RAM.
- `RAM_BE_A` out 2: byte enables to the RAM.
- `RAM_ADDR_A` out 14: write address to the RAM.
- `RAM_WDATA_A` out 18: write data to the RAM.
- `RAM_REN_B` out 1: read enable to the RAM.
- `RAM_ADDR_B` out 14: read address to the RAM.
- `RAM_RDATA_B` in 18: RAM read data; registered by the RAM, valid one cycle after `RAM_REN_B`.

## Operation
**Push accept**
- Push accepted = `PUSH & ~FULL`.
- On accept: `RAM_WEN_A` = 1, `RAM_BE_A` = 2'b11, `RAM_ADDR_A` = {wptr[9:0], 4'b0000}, `RAM_WDATA_A` = `WDATA`; wptr increments.
- All RAM port-A outputs are combinational from the inputs and the pointer.
- `RAM_WEN_A` = 0 and `RAM_BE_A` = 0 when no push is accepted.

**Pop accept**
- Pop accepted = `POP & ~EMPTY`.
- On accept: `RAM_REN_B` = 1, `RAM_ADDR_B` = {rptr[9:0], 4'b0000}; rptr increments.

**Pointers and count**
- wptr and rptr are 11 bits: the MSB is the wrap bit; bits [9:0] address the RAM.
- Increment is modulo 2048. Address wrap from 1023 to 0 is implicit.
- Next count = count + push_acc - pop_acc.
- Both accepted in the same cycle: count unchanged and pointers both advance. This is legal whenever `0 < count < 1024`.

**Flags and errors**
- All flags are registered from the next count: `FULL` = (count == 1024), `EMPTY` = (count == 0), plus the almost flags per the parameters.
- `PUSH` while `FULL` (including the cycle a pop is accepted): write dropped and `OVERFLOW` pulses next cycle. No same-cycle pass-through.
- `POP` while `EMPTY` (including the cycle a push is accepted): no read and `UNDERFLOW` pulses next cycle.

**Read data and flush**
- `RVALID` is the registered copy of pop_acc. `RDATA` = `RAM_RDATA_B` passed through combinationally while `RVALID`, else 0.
- `FLUSH` has priority over `PUSH` and `POP` in its cycle:
  - the RAM is not accessed;
  - next cycle pointers = 0, count = 0, `EMPTY` = 1, `ALMOST_EMPTY` = 1, all other flags 0, no error pulses;
  - an in-flight `RVALID` from the previous cycle still completes.

**Reset**
- Pointers, count, `RVALID`, `FULL`, `ALMOST_FULL`, `OVERFLOW`, `UNDERFLOW` = 0; `EMPTY` = 1, `ALMOST_EMPTY` = 1; `RDATA` = 0.
- Reset mid-operation discards the in-flight read, and `RVALID` drops immediately. RAM contents are not cleared and are treated as garbage.

## Timing
- Write latency: a word pushed at edge N is poppable at edge N+1 (`EMPTY` deasserts after edge N).
- Read latency: pop accepted at edge N gives `RVALID`/`RDATA` during cycle N+1, i.e. one cycle.
- Sustained push+pop gives one word per cycle in each direction.
- Flags and `COUNT` update on the edge that accepts the transaction. No lookahead.
- Read-during-write to the same address cannot occur: a pop needs count >= 1, so rptr != wptr[9:0] whenever both access the RAM in one cycle, except when count = 1024. In that case no push is accepted.

## Structure
- Package `ram18k_fifo_pkg` holds:
  - `FIFO_DEPTH` = 1024, `PTR_W` = 11, `DATA_W` = 18, `RAM_ADDR_W` = 14, `ADDR_LSB_PAD` = 4;
  - a function mapping a pointer to a 14-bit RAM address.
- Sub-module `ram18k_fifo_ptr` is an 11-bit pointer with increment and synchronous clear, plus RAM address output. It is instantiated twice (write and read).
- Flag and count logic stays in the top.

## Test plan
- Reset then idle: `EMPTY` = 1, `ALMOST_EMPTY` = 1, `COUNT` = 0, all RAM enables 0.
- Push 0x00001..0x00400 (1024 words): `FULL` rises after the 1024th, `ALMOST_FULL` after the 1008th. A 1025th push gives `OVERFLOW` pulse, `RAM_WEN_A` = 0 and `COUNT` stays 1024.
- Pop all 1024: `RDATA` sequence matches 0x00001..0x00400 with `RVALID` one cycle after each pop. A further pop gives `UNDERFLOW` pulse and `RAM_REN_B` = 0.
- Pre-fill 5, then 3000 cycles of simultaneous push/pop: `COUNT` stays 5, pointers wrap past 2047→0, and data order is preserved across the 1023→0 address wrap.
- Push and pop in the same cycle while `EMPTY`: push accepted, `UNDERFLOW` pulses, `COUNT` = 1. Pop and push while `FULL`: pop accepted, `OVERFLOW` pulses, `COUNT` = 1023.
- `FLUSH` with 10 words stored and `PUSH`/`POP` high: next cycle `COUNT` = 0 and `EMPTY` = 1. `RESET_N` low during an outstanding pop: `RVALID` drops immediately and nothing is delivered after release.
